// File: rtl/upscale_stream_feeder.sv
// Ping-pong row buffer that replays each native row SCALE times vertically and
// each pixel SCALE times horizontally, tagging every beat with its phase indices.
module upscale_stream_feeder #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 72,
  parameter int SCALE = 3,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_pixel,
  output logic             m_valid,
  output logic [1:0]       m_h_phase,
  output logic [1:0]       m_v_phase,
  output logic             m_sol,
  output logic             m_eof,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [1:0]    PH_LAST  = 2'(SCALE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [PIX_W-1:0] mem [2][IMG_W];
  logic [1:0]       full_q;
  logic             wr_bank_q;
  logic [CW-1:0]    wr_col_q;
  logic             rd_bank_q;
  state_t           state_q, state_d;
  logic [CW-1:0]    col_q;
  logic [1:0]       h_q, v_q;
  logic [RW-1:0]    row_cnt_q;
  logic             row_done_q, done_bank_q;
  logic             wr_fire, wr_row_end;
  logic             issue, last_h, last_col, last_v, row_end;

  assign s_ready    = ~rst & ~full_q[wr_bank_q];
  assign wr_fire    = s_valid & s_ready;
  assign wr_row_end = wr_fire && (wr_col_q == COL_LAST);
  assign busy       = (|full_q) | (state_q == EMIT) | m_valid;

  // NOTE: the pixel store has no reset; the full flags alone say which contents are live.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_col_q] <= s_pixel;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // sample pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_col_q  <= '0;
    end else if (wr_fire) begin
      if (wr_row_end) begin
        wr_col_q  <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else begin
        wr_col_q <= wr_col_q + CW'(1);
      end
    end
  end

  // The freed bank is released one cycle after its last beat is on the output;
  // it is always the opposite bank from any write completing in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
    end else begin
      if (row_done_q) full_q[done_bank_q] <= 1'b0;
      if (wr_row_end) full_q[wr_bank_q]   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaults come first so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    last_h   = (h_q == PH_LAST);
    last_col = (col_q == COL_LAST);
    last_v   = (v_q == PH_LAST);
    row_end  = last_h && last_col && last_v;
    case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = EMIT;
      EMIT: begin
        issue = 1'b1;
        if (row_end && !full_q[~rd_bank_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q       <= '0;
      v_q       <= '0;
      col_q     <= '0;
      rd_bank_q <= 1'b0;
      row_cnt_q <= '0;
    end else if (issue) begin
      h_q <= last_h ? 2'd0 : h_q + 2'd1;
      if (last_h) begin
        col_q <= last_col ? '0 : col_q + CW'(1);
        if (last_col) v_q <= last_v ? 2'd0 : v_q + 2'd1;
      end
      if (row_end) begin
        rd_bank_q <= ~rd_bank_q;
        row_cnt_q <= (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
      end
    end
  end

  // The bank read lands directly in the output register; idle beats are zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_pixel     <= '0;
      m_h_phase   <= '0;
      m_v_phase   <= '0;
      m_sol       <= 1'b0;
      m_eof       <= 1'b0;
      frame_done  <= 1'b0;
      row_done_q  <= 1'b0;
      done_bank_q <= 1'b0;
    end else begin
      m_valid     <= issue;
      m_pixel     <= issue ? mem[rd_bank_q][col_q] : '0;
      m_h_phase   <= issue ? h_q : 2'd0;
      m_v_phase   <= issue ? v_q : 2'd0;
      m_sol       <= issue && (col_q == '0) && (h_q == 2'd0);
      m_eof       <= issue && row_end && (row_cnt_q == ROW_LAST);
      frame_done  <= m_eof;
      row_done_q  <= issue && row_end;
      done_bank_q <= rd_bank_q;
    end
  end

endmodule

// File: tb/tb_upscale_stream_feeder.sv
// Self-checking bench: a queue-based model expands every completed input row into
// its replicated beat sequence; a negedge monitor compares the DUT against it.
module tb_upscale_stream_feeder;

  localparam int W = 4;
  localparam int H = 2;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_pixel;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_pixel;
  logic       m_valid;
  logic [1:0] m_h_phase, m_v_phase;
  logic       m_sol, m_eof, frame_done, busy;

  upscale_stream_feeder #(.IMG_W(W), .IMG_H(H), .SCALE(S), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_h_phase(m_h_phase), .m_v_phase(m_v_phase),
    .m_sol(m_sol), .m_eof(m_eof), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic [1:0] h, v;
    logic       sol, eof, first, last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] rowbuf[$];
  int         edge_q[$];
  int checks, errors, cyc;
  int rows_in, rows_out, beats, idle_starts, eof_seen;
  logic prev_valid, prev_eof;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model.
  always @(negedge clk) begin : monitor
    beat_t      e;
    int         occ;
    logic [13:0] act, expv;
    if (rst) begin
      check("rst_outputs", 32'({m_valid, m_pixel, m_h_phase, m_v_phase, m_sol, m_eof,
                                frame_done, busy, s_ready}), 0);
    end else begin
      occ = rows_in - rows_out;
      check("s_ready", 32'(s_ready), 32'(occ < 2));
      check("busy", 32'(busy), 32'(occ > 0));
      check("frame_done", 32'(frame_done), 32'(prev_eof));
      act = {m_pixel, m_h_phase, m_v_phase, m_sol, m_eof};
      prev_eof = 1'b0;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_valid), 0);
        end else begin
          e = exp_q.pop_front();
          expv = {e.pix, e.h, e.v, e.sol, e.eof};
          check("beat", 32'(act), 32'(expv));
          beats++;
          if (e.eof) eof_seen++;
          prev_eof = e.eof;
          if (e.first) begin
            if (edge_q.size() != 0) begin
              if (!prev_valid) begin
                check("start_latency", 32'(cyc - edge_q[0]), 2);
                idle_starts++;
              end
              void'(edge_q.pop_front());
            end
          end else begin
            check("contiguous", 32'(prev_valid), 1);
          end
          if (e.last) rows_out++;
        end
      end else begin
        check("idle_zero", 32'(act), 0);
      end
      prev_valid = m_valid;
      if (s_valid && s_ready) begin
        rowbuf.push_back(s_pixel);
        if (rowbuf.size() == W) begin
          for (int v = 0; v < S; v++)
            for (int c = 0; c < W; c++)
              for (int h = 0; h < S; h++) begin
                e.pix   = rowbuf[c];
                e.h     = 2'(h);
                e.v     = 2'(v);
                e.sol   = (c == 0) && (h == 0);
                e.first = (v == 0) && (c == 0) && (h == 0);
                e.last  = (v == S-1) && (c == W-1) && (h == S-1);
                e.eof   = e.last && ((rows_in % H) == H-1);
                exp_q.push_back(e);
              end
          rows_in++;
          edge_q.push_back(cyc + 1);
          rowbuf.delete();
        end
      end
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    s_pixel = '0;
    rst     = 1'b1;
    exp_q.delete(); rowbuf.delete(); edge_q.delete();
    rows_in = 0; rows_out = 0; beats = 0; idle_starts = 0; eof_seen = 0;
    prev_valid = 1'b0; prev_eof = 1'b0;
    #1;
    check("rst_now_outputs", 32'({m_valid, m_pixel, m_h_phase, m_v_phase, m_sol, m_eof,
                                  frame_done, busy}), 0);
    check("rst_now_ready", 32'(s_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_release_ready", 32'(s_ready), 1);
  endtask

  task automatic drive(input logic [7:0] p);
    int n = 0;
    s_valid = 1'b1;
    s_pixel = p;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_pixel = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rows_in != rows_out || m_valid) && n < 3000) begin
      idle(1);
      n++;
    end
    check("drain_timeout", 32'(n < 3000), 1);
    idle(3);
  endtask

  initial begin
    logic [7:0] row_a [4];
    int n;
    row_a = '{8'd10, 8'd20, 8'd30, 8'd40};
    cyc = 0; checks = 0; errors = 0;

    // Single row, back-to-back.
    do_reset();
    for (int i = 0; i < W; i++) drive(row_a[i]);
    wait_drain();
    check("t1_beats", 32'(beats), 36);
    check("t1_idle_starts", 32'(idle_starts), 1);

    // Backpressure: three rows offered continuously.
    do_reset();
    for (int i = 0; i < 12; i++) drive(8'(i + 1));
    wait_drain();
    check("t2_beats", 32'(beats), 108);
    check("t2_idle_starts", 32'(idle_starts), 1);
    check("t2_eof_count", 32'(eof_seen), 1);

    // Frame end, then a new frame.
    do_reset();
    for (int i = 0; i < 2*W; i++) drive(8'(8'h50 + i));
    wait_drain();
    check("t3_frame_beats", 32'(beats), 72);
    check("t3_eof_count", 32'(eof_seen), 1);
    for (int i = 0; i < W; i++) drive(8'(8'h90 + i));
    wait_drain();
    check("t3_next_frame_beats", 32'(beats), 108);
    check("t3_next_eof_count", 32'(eof_seen), 1);

    // Sparse input.
    do_reset();
    for (int i = 0; i < W; i++) begin
      drive(row_a[i]);
      idle(2);
    end
    wait_drain();
    check("t4_beats", 32'(beats), 36);
    check("t4_idle_starts", 32'(idle_starts), 1);

    // Reset in the middle of an emission.
    do_reset();
    for (int i = 0; i < W; i++) drive(8'(5 + i));
    n = 0;
    while (beats < 14 && n < 200) begin
      idle(1);
      n++;
    end
    check("t5_wait_timeout", 32'(beats >= 14), 1);
    do_reset();
    for (int i = 0; i < W; i++) drive(8'(1 + i));
    wait_drain();
    check("t5_beats", 32'(beats), 36);

    // Randomized rows and gaps across three frames.
    do_reset();
    for (int i = 0; i < 6*W; i++) begin
      drive(8'($urandom_range(0, 255)));
      idle(int'($urandom_range(0, 3)));
    end
    wait_drain();
    check("t6_beats", 32'(beats), 216);
    check("t6_eof_count", 32'(eof_seen), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upscale_stream_feeder.md
Name: upscale_stream_feeder

Overview:
Transmit-side companion to the bicubic upscaler datapath. Accepts a native-resolution pixel stream and re-emits it in the replicated order the upscaler consumes: each pixel SCALE times horizontally, each row SCALE times vertically. Each beat carries its horizontal and vertical phase indices. Ping-pong row buffering lets the next input row load while the current row is replayed.

Parameters:
IMG_W, 128, input pixels per row
IMG_H, 72, input rows per frame
SCALE, 3, replication factor per axis (2..4; phases fit in 2 bits)
PIX_W, 8, pixel width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
s_pixel  input  PIX_W  native input pixel
s_valid  input  1  input beat valid
s_ready  output  1  feeder can accept a beat; transfer when s_valid && s_ready
m_pixel  output  PIX_W  replicated output pixel (drives upscaler pixel_in)
m_valid  output  1  output beat valid (drives upscaler input_valid); no backpressure
m_h_phase  output  2  horizontal phase of this beat, 0..SCALE-1
m_v_phase  output  2  vertical phase of this beat, 0..SCALE-1
m_sol  output  1  first beat of each replicated output row
m_eof  output  1  last beat of the frame
frame_done  output  1  one-cycle pulse the cycle after the m_eof beat
busy  output  1  any bank full or emission in progress

Behaviour:
- Reset (async, rst=1): all outputs 0 except s_ready=0 while rst is asserted, then s_ready=1 on the first cycle after release. Both banks empty, all counters 0, read FSM in IDLE. A reset mid-row or mid-emission discards all buffered data.
- Storage: two IMG_W x PIX_W banks, each with a full flag. Write pointer is wr_bank/wr_col; read pointer is rd_bank.
- Write side:
  - s_ready = !full[wr_bank].
  - On each accepted beat, store at wr_col and increment wr_col.
  - On the beat at wr_col==IMG_W-1: set full[wr_bank], toggle wr_bank, set wr_col=0.
  - Gaps in s_valid are allowed anywhere.
- Read FSM states:
  - IDLE: go to EMIT when full[rd_bank]=1.
  - EMIT: one beat per clock, unconditionally. Loop nesting, outermost first: v (0..SCALE-1), col (0..IMG_W-1), h (0..SCALE-1).
  - After the beat with v=SCALE-1, col=IMG_W-1, h=SCALE-1: clear full[rd_bank], toggle rd_bank, increment row_cnt.
  - After that last beat, if the next bank is already full, stay in EMIT with no gap cycle; otherwise go to IDLE.
- Outputs are registered; the bank read is a synchronous read.
  - The first m_valid of a row appears exactly 2 cycles after the handshake of that row's last input pixel, when the FSM was IDLE.
  - m_pixel is held constant across the SCALE beats of one column.
  - m_h_phase/m_v_phase equal the h/v loop indices of the beat.
  - m_sol=1 when col==0 && h==0.
- Frame end:
  - On the last beat of row IMG_H-1, m_eof=1.
  - frame_done pulses the following cycle, then row_cnt resets to 0.
  - Input for the next frame may already be loading into the free bank.
- Beats per frame: IMG_W*IMG_H*SCALE^2.
- When m_valid=0, m_pixel, the phases, m_sol and m_eof are all 0.
- Same-cycle events:
  - A write completing bank X while the read frees bank Y (X!=Y): both take effect.
  - A write cannot target a full bank, because s_ready gates it.
- Steady state: input throughput is 1 row per IMG_W*SCALE^2 cycles, and s_ready is low whenever both banks are full.

Test Plan:
(All cases use IMG_W=4, IMG_H=2, SCALE=3.)
- Single row: 10,20,30,40 fed back-to-back.
  -> First m_valid 2 cycles after the handshake of 40.
  -> 36 contiguous beats: 10,10,10,20,20,20,30,30,30,40,40,40, repeated 3 times.
  -> m_h_phase cycles 0,1,2; m_v_phase is 0 for beats 1-12, 1 for 13-24, 2 for 25-36; m_sol on beats 1,13,25.
- Backpressure: 12 pixels offered continuously.
  -> s_ready drops after the 8th accept (both banks full).
  -> s_ready rises the cycle after beat 36 of row 0.
  -> Row 1 beats follow row 0's with no gap.
- Frame end: 2 rows.
  -> m_eof on beat 72 only; frame_done pulses at beat 72+1.
  -> A third row then starts a new frame with m_v_phase=0 and row_cnt=0.
- Sparse input: s_valid toggled 1,0,0,1,...
  -> Output content is identical to the single-row case.
  -> Emission starts only after the 4th accept.
- Reset mid-emission: assert rst at beat 15.
  -> m_valid=0 immediately and all outputs 0.
  -> After release, s_ready=1 and a fresh row 1,2,3,4 emits correctly from v_phase 0.
- Phase/ordering check: after each reset, a scoreboard compares m_h_phase and m_v_phase against the upscaler's mod-3 phase sequence for a full frame.
